// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  localparam int MIN_IDX_W = 1;

  // Index width for an n-way selector; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : MIN_IDX_W;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Round-robin picker: rotate requests so rr_ptr_i sits at bit 0, then take the lowest set bit.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic               any_req_o,
  output logic [IDX_W-1:0]   pick_o
);

  localparam logic [IDX_W:0] N_EXT = (IDX_W+1)'(NUM_REQ);

  logic [NUM_REQ-1:0] rot;
  logic [IDX_W:0]     sum;
  logic [IDX_W:0]     off;
  logic [IDX_W:0]     sel;

  always_comb begin
    rot = '0;
    sum = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr_i} + (IDX_W+1)'(k);
      if (sum >= N_EXT) sum = sum - N_EXT;
      rot[k] = req_i[sum[IDX_W-1:0]];
    end

    off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) off = (IDX_W+1)'(k);
    end

    sel = {1'b0, rr_ptr_i} + off;
    if (sel >= N_EXT) sel = sel - N_EXT;

    any_req_o = |req_i;
    pick_o    = sel[IDX_W-1:0];
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ valid/ready producers.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int BURST_LEN  = 4,
  localparam int IDX_W      = idx_width(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr,
  output logic [DATA_WIDTH-1:0]         fifo_w_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic [IDX_W-1:0]              grant_id,
  output logic                          busy
);

  localparam int               CNT_W     = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

  arb_state_t             state_q, state_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;

  logic                   any_req;
  logic [IDX_W-1:0]       pick;
  logic                   owner_vld;
  logic [DATA_WIDTH-1:0]  owner_data;
  logic                   xfer;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_i     (req_valid),
    .rr_ptr_i  (rr_ptr_q),
    .any_req_o (any_req),
    .pick_o    (pick)
  );

  always_comb begin
    owner_vld  = 1'b0;
    owner_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == IDX_W'(i)) begin
        owner_vld  = req_valid[i];
        owner_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Reset gates the strobe directly so a mid-burst reset never writes.
  assign xfer = (state_q == ARB_GRANT) & owner_vld & ~fifo_full & ~reset;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ARB_IDLE: begin
        beat_cnt_d = '0;
        if (any_req) begin
          state_d = ARB_GRANT;
          owner_d = pick;
        end
      end
      ARB_GRANT: begin
        if (!owner_vld || (xfer && (beat_cnt_q == LAST_BEAT))) begin
          state_d    = ARB_IDLE;
          beat_cnt_d = '0;
          rr_ptr_d   = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
        end else if (xfer) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    req_ready   = '0;
    grant       = '0;
    grant_id    = '0;
    busy        = 1'b0;
    fifo_wr     = 1'b0;
    fifo_w_data = '0;
    if (state_q == ARB_GRANT) begin
      busy        = 1'b1;
      grant_id    = owner_q;
      fifo_wr     = xfer;
      fifo_w_data = owner_data;
      for (int i = 0; i < NUM_REQ; i++) begin
        grant[i]     = (owner_q == IDX_W'(i));
        req_ready[i] = (owner_q == IDX_W'(i)) & ~fifo_full & ~reset;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ARB_IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule
